// File: rtl/overlap_add_if.sv
// Sample-stream bundle for overlap_add: framed input handshake plus
// reconstructed-output stream with index and end-of-utterance marker.
interface overlap_add_if #(
    parameter int I_BW  = 14,
    parameter int O_BW  = 14,
    parameter int ON_BW = 14
);
    logic                   di_en;
    logic signed [I_BW-1:0] data_i;
    logic                   di_rdy;
    logic                   do_en;
    logic signed [O_BW-1:0] data_o;
    logic [ON_BW-1:0]       out_num;
    logic                   done;

    modport master (
        output di_en, data_i,
        input  di_rdy, do_en, data_o, out_num, done
    );

    modport slave (
        input  di_en, data_i,
        output di_rdy, do_en, data_o, out_num, done
    );
endinterface

// File: rtl/overlap_add.sv
// Overlap-add reconstruction: frames of FRAME_LEN samples, advanced by HOP,
// are summed into a circular accumulator; each completed hop is read out
// (saturated) and cleared, and the tail is flushed after the last frame.
module overlap_add #(
    parameter int I_BW       = 14,
    parameter int O_BW       = 14,
    parameter int FRAME_LEN  = 1024,
    parameter int HOP        = 160,
    parameter int NUM_FRAMES = 89
) (
    input  logic         clk,
    input  logic         rst,
    overlap_add_if.slave bus
);
    localparam int TOTAL  = (NUM_FRAMES - 1) * HOP + FRAME_LEN;
    localparam int ON_BW  = $clog2(TOTAL);
    localparam int ACC_BW = I_BW + $clog2((FRAME_LEN + HOP - 1) / HOP);
    localparam int AW     = $clog2(FRAME_LEN);
    localparam int FW     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int SW     = ((ACC_BW > O_BW) ? ACC_BW : O_BW) + 1;

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [AW-1:0]    LAST_K   = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0]    LAST_HOP = AW'(HOP - 1);
    localparam logic [AW-1:0]    HOP_STEP = AW'(HOP);
    localparam logic [FW-1:0]    LAST_F   = FW'(NUM_FRAMES - 1);
    localparam logic [ON_BW-1:0] LAST_OUT = ON_BW'(TOTAL - 1);

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-O_BW+1){1'b1}}, {(O_BW-1){1'b0}}};

    logic [1:0]               state;
    logic [AW-1:0]            base;
    logic [AW-1:0]            k;
    logic [AW-1:0]            cnt;
    logic [FW-1:0]            f;
    logic signed [ACC_BW-1:0] acc [FRAME_LEN];

    logic [AW-1:0]            addr;
    logic signed [ACC_BW-1:0] rd;
    logic signed [ACC_BW-1:0] din_ext;
    logic signed [ACC_BW-1:0] wr_data;
    logic signed [SW-1:0]     rd_ext;
    logic signed [O_BW-1:0]   sat;
    logic                     accept;
    logic                     reading;
    logic                     wr_en;

    logic                     do_en_q;
    logic signed [O_BW-1:0]   data_o_q;
    logic [ON_BW-1:0]         out_num_q;

    assign accept  = bus.di_en & (state == S_ACCUM);
    assign reading = (state == S_DRAIN) | (state == S_FLUSH);
    assign din_ext = {{(ACC_BW-I_BW){bus.data_i[I_BW-1]}}, bus.data_i};

    // CLEAR sweeps from entry 0; ACCUM and DRAIN/FLUSH address relative to base,
    // so power-of-two truncation gives the circular wrap for free.
    assign addr    = (state == S_CLEAR) ? cnt : base + ((state == S_ACCUM) ? k : cnt);
    assign rd      = acc[addr];
    assign wr_en   = (state != S_ACCUM) | accept;
    assign wr_data = accept ? rd + din_ext : '0;
    assign rd_ext  = {{(SW-ACC_BW){rd[ACC_BW-1]}}, rd};

    // Sequence control: clear sweep, per-sample accumulate, hop drain, final flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CLEAR;
            base  <= '0;
            k     <= '0;
            cnt   <= '0;
            f     <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (cnt == LAST_K) begin
                        state <= S_ACCUM;
                        cnt   <= '0;
                        base  <= '0;
                        k     <= '0;
                        f     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        if (k == LAST_K) begin
                            k     <= '0;
                            cnt   <= '0;
                            state <= (f < LAST_F) ? S_DRAIN : S_FLUSH;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt == LAST_HOP) begin
                        cnt   <= '0;
                        base  <= base + HOP_STEP;
                        f     <= f + 1'b1;
                        state <= S_ACCUM;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == LAST_K) begin
                        cnt   <= '0;
                        base  <= '0;
                        f     <= '0;
                        state <= S_ACCUM;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Accumulator storage: one read-modify-write or clear per cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            acc[addr] <= wr_data;
        end
    end

    // Clamp the accumulated entry into the signed output range.
    always_comb begin
        if (rd_ext > SAT_MAX) begin
            sat = SAT_MAX[O_BW-1:0];
        end else if (rd_ext < SAT_MIN) begin
            sat = SAT_MIN[O_BW-1:0];
        end else begin
            sat = rd_ext[O_BW-1:0];
        end
    end

    // Output register: out_num shows the index of the sample presented with
    // do_en and advances once that sample has been emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_en_q   <= 1'b0;
            data_o_q  <= '0;
            out_num_q <= '0;
        end else begin
            do_en_q <= reading;
            if (reading) begin
                data_o_q <= sat;
            end
            if (do_en_q) begin
                out_num_q <= (out_num_q == LAST_OUT) ? '0 : out_num_q + 1'b1;
            end
        end
    end

    assign bus.di_rdy  = (state == S_ACCUM);
    assign bus.do_en   = do_en_q;
    assign bus.data_o  = data_o_q;
    assign bus.out_num = out_num_q;
    assign bus.done    = do_en_q & (out_num_q == LAST_OUT);
endmodule

// File: doc/overlap_add.md
OVERLAP_ADD -- requirements
Module: overlap_add

Interface
REQ-001 The module SHALL have parameter I_BW, default 14, meaning signed input sample width.
REQ-002 The module SHALL have parameter O_BW, default 14, meaning signed output sample width.
REQ-003 The module SHALL have parameter FRAME_LEN, default 1024, meaning samples per frame (power of two).
REQ-004 The module SHALL have parameter HOP, default 160, meaning frame advance in samples (HOP < FRAME_LEN).
REQ-005 The module SHALL have parameter NUM_FRAMES, default 89, meaning frames per utterance.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 The module SHALL have port di_en, input, 1 bit: input sample valid.
REQ-009 The module SHALL have port data_i, input, I_BW bits: signed frame sample, frames streamed back-to-back in sample order.
REQ-010 The module SHALL have port di_rdy, output, 1 bit: high when an input sample can be accepted; a sample is accepted only when di_en & di_rdy.
REQ-011 The module SHALL have port do_en, output, 1 bit: output sample valid.
REQ-012 The module SHALL have port data_o, output, O_BW bits: signed reconstructed sample.
REQ-013 The module SHALL have port out_num, output, $clog2((NUM_FRAMES-1)*HOP+FRAME_LEN) bits: index of the current output sample.
REQ-014 The module SHALL have port done, output, 1 bit: one-cycle pulse coincident with the last output sample of an utterance.

Function
REQ-015 The module SHALL hold a FRAME_LEN-entry circular accumulator of width ACC_BW = I_BW + $clog2(ceil(FRAME_LEN/HOP)) (17 at defaults), with base pointer base, in-frame counter k and frame counter f.
REQ-016 The state machine SHALL have states CLEAR, ACCUM, DRAIN and FLUSH, and di_rdy SHALL be high only in ACCUM.
REQ-017 CLEAR SHALL write zero to one entry per cycle for FRAME_LEN cycles, then enter ACCUM with base=0, k=0, f=0.
REQ-018 In ACCUM, each accepted sample SHALL update entry (base+k) mod FRAME_LEN to that entry plus sign-extended data_i, then increment k.
REQ-019 Acceptance of sample k=FRAME_LEN-1 SHALL enter DRAIN when f<NUM_FRAMES-1, otherwise FLUSH; k SHALL reset to 0.
REQ-020 DRAIN SHALL last exactly HOP cycles; cycle j reads entry (base+j) mod FRAME_LEN and clears it to zero.
REQ-021 On DRAIN exit, base SHALL become (base+HOP) mod FRAME_LEN, f SHALL increment, and the state SHALL return to ACCUM.
REQ-022 FLUSH SHALL last exactly FRAME_LEN cycles reading and clearing entries from base onward, then return to ACCUM with base=0 and f=0.
REQ-023 Every read in DRAIN or FLUSH SHALL produce do_en=1 on the following cycle, with data_o equal to the entry saturated to [-2^(O_BW-1), 2^(O_BW-1)-1].
REQ-024 out_num SHALL increment after each output, run 0..15103 at defaults, and wrap to 0 after the last output.
REQ-025 done SHALL assert with the output whose out_num equals the final index.
REQ-026 di_en asserted while di_rdy=0 SHALL be ignored, with no state or counter change.
REQ-027 When ACCUM is idle (di_en=0), all state SHALL hold indefinitely.

Reset
REQ-028 Asserting rst SHALL immediately force do_en=0, data_o=0, out_num=0, done=0, di_rdy=0, k=0, f=0, base=0 and state CLEAR, including mid-frame, mid-DRAIN and mid-FLUSH.
REQ-029 After rst deasserts, di_rdy SHALL rise after exactly FRAME_LEN cycles of CLEAR, and the prior partial accumulation SHALL be discarded.

Verification
REQ-030 Constant-one test: release reset and feed 89 frames of all-ones -> 15104 outputs; samples 0..159 = 1; samples 160..319 = 2; interior samples equal their frame-coverage count (6 or 7); the last output = 1 with done=1.
REQ-031 Impulse test: frame 0 sample 5 = 100, all other samples 0 -> out_num 5 outputs 100; every other output is 0.
REQ-032 Saturation test: all samples 8191 -> interior outputs 8191; all samples -8192 -> interior outputs -8192; no wrap.
REQ-033 Backpressure test: hold di_en=1 continuously -> exactly 1024 samples accepted per frame; di_rdy is low for exactly 160 cycles between frames 0..87 and for 1024 cycles after frame 88.
REQ-034 Reset test: pulse rst after 500 samples of frame 3 -> outputs clear at once; di_rdy is low for 1024 cycles; a fresh constant-one run then matches REQ-030 exactly.
REQ-035 Back-to-back test: two utterances with no gap -> out_num wraps 15103 -> 0, and the second run's outputs equal the first run's.
